// File: rtl/glyph_loader_pkg.sv
//------------------------------------------------------------------------------
// Module      : glyph_loader_pkg
// Description : Shared types and constants for the glyph burst loader.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package glyph_loader_pkg;

    localparam int unsigned GLYPH_DATA_W = 128;
    localparam int unsigned GLYPH_LANE_W = 32;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        READ        = 2'd1,
        DRAIN       = 2'd2,
        WAIT_COMMIT = 2'd3
    } state_t;

    // Number of LANE_W lanes in one DATA_W glyph word.
    function automatic int unsigned lane_count(input int unsigned data_w,
                                               input int unsigned lane_w);
        return data_w / lane_w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/glyph_bank_ram.sv
//------------------------------------------------------------------------------
// Module      : glyph_bank_ram
// Description : Two NUM_WORDS x DATA_W register banks, one write port and one
//               registered read port; out-of-range read addresses return 0.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module glyph_bank_ram #(
    parameter int unsigned DATA_W    = 128,
    parameter int unsigned NUM_WORDS = 32,
    parameter int unsigned AW        = 5
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              wr_bank,
    input  logic [AW-1:0]     wr_idx,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              we,
    input  logic              rd_bank,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] r_bank0 [NUM_WORDS];
    logic [DATA_W-1:0] r_bank1 [NUM_WORDS];
    logic [DATA_W-1:0] w_rd_word;
    logic [DATA_W-1:0] r_rd_data;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NUM_WORDS; i++) begin
                r_bank0[i] <= '0;
                r_bank1[i] <= '0;
            end
        end else if (we) begin
            for (int i = 0; i < NUM_WORDS; i++) begin
                if (wr_idx == AW'(i)) begin
                    if (wr_bank) r_bank1[i] <= wr_data;
                    else         r_bank0[i] <= wr_data;
                end
            end
        end
    end

    // Address decode by comparison so indices beyond NUM_WORDS fall through to 0.
    always_comb begin
        w_rd_word = '0;
        for (int i = 0; i < NUM_WORDS; i++) begin
            if (rd_addr == AW'(i)) begin
                w_rd_word = rd_bank ? r_bank1[i] : r_bank0[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_rd_data <= '0;
        else       r_rd_data <= w_rd_word;
    end

    assign rd_data = r_rd_data;

endmodule

`default_nettype wire

// File: rtl/glyph_burst_loader.sv
//------------------------------------------------------------------------------
// Module      : glyph_burst_loader
// Description : Pops one NUM_WORDS glyph set from the async FIFO into a shadow
//               bank and swaps it to display on the next vsync.
//               Optional build macro GLYPH_LANE_SWAP_EN reverses LANE_W lanes.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module glyph_burst_loader
    import glyph_loader_pkg::*;
#(
    parameter int unsigned DATA_W    = GLYPH_DATA_W,
    parameter int unsigned LANE_W    = GLYPH_LANE_W,
    parameter int unsigned NUM_WORDS = 32,
    parameter int unsigned LVL_W     = 8,
    parameter int unsigned AW        = 5
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [LVL_W-1:0]  fifo_waterlevel,
    input  logic [DATA_W-1:0] fifo_rd_data,
    output logic              fifo_rd_en,
    input  logic              load_en,
    input  logic              vsync,
    input  logic [AW-1:0]     glyph_addr,
    output logic [DATA_W-1:0] glyph_data,
    output logic              load_done,
    output logic              bank_sel,
    output logic              busy
);

    localparam int unsigned      C_NUM_LANES = lane_count(DATA_W, LANE_W);
    localparam logic [AW-1:0]    C_LAST_IDX  = AW'(NUM_WORDS - 1);
    localparam logic [LVL_W-1:0] C_BURST_LVL = LVL_W'(NUM_WORDS);
    localparam logic [AW-1:0]    C_ONE       = AW'(1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_fifo_rd_en;
    logic              w_fifo_rd_en_nxt;
    logic              r_rd_vld;
    logic              r_load_done;
    logic              w_load_done_nxt;
    logic              r_bank_sel;
    logic              w_bank_sel_nxt;
    logic [AW-1:0]     r_rd_cnt;
    logic [AW-1:0]     r_wr_idx;
    logic              w_start;
    logic              w_shadow_bank;
    logic [DATA_W-1:0] w_wr_data;

    assign w_start = load_en && (fifo_waterlevel >= C_BURST_LVL);

    always_comb begin
        w_state_nxt      = r_state;
        w_fifo_rd_en_nxt = 1'b0;
        w_load_done_nxt  = 1'b0;
        w_bank_sel_nxt   = r_bank_sel;
        case (r_state)
            IDLE: begin
                if (w_start) begin
                    w_state_nxt      = READ;
                    w_fifo_rd_en_nxt = 1'b1;
                end
            end
            READ: begin
                if (r_rd_cnt == C_LAST_IDX) begin
                    w_state_nxt = DRAIN;
                end else begin
                    w_fifo_rd_en_nxt = 1'b1;
                end
            end
            DRAIN: begin
                w_state_nxt = WAIT_COMMIT;
            end
            WAIT_COMMIT: begin
                if (vsync) begin
                    w_state_nxt     = IDLE;
                    w_load_done_nxt = 1'b1;
                    w_bank_sel_nxt  = ~r_bank_sel;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state      <= IDLE;
            r_fifo_rd_en <= 1'b0;
            r_rd_vld     <= 1'b0;
            r_load_done  <= 1'b0;
            r_bank_sel   <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_fifo_rd_en <= w_fifo_rd_en_nxt;
            r_rd_vld     <= r_fifo_rd_en;
            r_load_done  <= w_load_done_nxt;
            r_bank_sel   <= w_bank_sel_nxt;
        end
    end

    // Both counters restart on the IDLE->READ transition; the previous burst's
    // last write has already landed in DRAIN by then.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rd_cnt <= '0;
            r_wr_idx <= '0;
        end else if (r_state == IDLE && w_start) begin
            r_rd_cnt <= '0;
            r_wr_idx <= '0;
        end else begin
            if (r_state == READ) r_rd_cnt <= r_rd_cnt + C_ONE;
            if (r_rd_vld)        r_wr_idx <= r_wr_idx + C_ONE;
        end
    end

    for (genvar gl = 0; gl < C_NUM_LANES; gl++) begin : g_lane
`ifdef GLYPH_LANE_SWAP_EN
        assign w_wr_data[(C_NUM_LANES-1-gl)*LANE_W +: LANE_W] = fifo_rd_data[gl*LANE_W +: LANE_W];
`else
        assign w_wr_data[gl*LANE_W +: LANE_W] = fifo_rd_data[gl*LANE_W +: LANE_W];
`endif
    end

    assign w_shadow_bank = ~r_bank_sel;

    glyph_bank_ram #(
        .DATA_W    (DATA_W),
        .NUM_WORDS (NUM_WORDS),
        .AW        (AW)
    ) u_bank_ram (
        .clk     (clk),
        .rstn    (rstn),
        .wr_bank (w_shadow_bank),
        .wr_idx  (r_wr_idx),
        .wr_data (w_wr_data),
        .we      (r_rd_vld),
        .rd_bank (r_bank_sel),
        .rd_addr (glyph_addr),
        .rd_data (glyph_data)
    );

    assign fifo_rd_en = r_fifo_rd_en;
    assign load_done  = r_load_done;
    assign bank_sel   = r_bank_sel;
    assign busy       = (r_state != IDLE);

endmodule

`default_nettype wire
